// File: rtl/ahb_arbiter_if.sv
// Shared request/bus bundle between two masters, the arbiter and one slave.
// The master modport is the arbiter's view; slave is the view from the other side.
interface ahb_arbiter_if;
    logic [1:0]  M_REQ;
    logic [1:0]  M_WRITE;
    logic [7:0]  M_ADDR;
    logic [63:0] M_WDATA;
    logic [1:0]  M_GNT;
    logic [1:0]  M_DONE;
    logic [31:0] M_RDATA;
    logic [3:0]  HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HVALID;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        TIMEOUT;

    modport master (
        input  M_REQ, M_WRITE, M_ADDR, M_WDATA, HRDATA, HREADY,
        output M_GNT, M_DONE, M_RDATA, HADDR, HWRITE, HWDATA,
        output HVALID, TIMEOUT
    );

    modport slave (
        output M_REQ, M_WRITE, M_ADDR, M_WDATA, HRDATA, HREADY,
        input  M_GNT, M_DONE, M_RDATA, HADDR, HWRITE, HWDATA,
        input  HVALID, TIMEOUT
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Two-master round-robin arbiter driving a single-slave bus (IDLE/ADDR/DATA).
// Optional DATA-phase abort is enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state;
    logic   last;
    logic   cur;
    logic   win;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // On a tie the master that did not finish last wins.
    always_comb win = (bus.M_REQ == 2'b11) ? ~last : bus.M_REQ[1];

`ifdef AHB_ARB_TIMEOUT_EN
    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);
    logic [7:0] cnt;
    logic [8:0] cnt_nx;
    always_comb cnt_nx = {1'b0, cnt} + 9'd1;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            last        <= 1'b1;
            cur         <= 1'b0;
            bus.M_GNT   <= '0;
            bus.M_DONE  <= '0;
            bus.M_RDATA <= '0;
            bus.HADDR   <= '0;
            bus.HWRITE  <= 1'b0;
            bus.HWDATA  <= '0;
            bus.HVALID  <= 1'b0;
            bus.TIMEOUT <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            bus.M_GNT   <= '0;
            bus.M_DONE  <= '0;
            bus.TIMEOUT <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.M_REQ) begin
                        cur        <= win;
                        bus.M_GNT  <= win ? 2'b10 : 2'b01;
                        bus.HVALID <= 1'b1;
                        bus.HWRITE <= bus.M_WRITE[win];
                        bus.HADDR  <= win ? bus.M_ADDR[7:4]
                                          : bus.M_ADDR[3:0];
                        bus.HWDATA <= win ? bus.M_WDATA[63:32]
                                          : bus.M_WDATA[31:0];
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    bus.HVALID <= 1'b0;
                    state      <= DATA;
`ifdef AHB_ARB_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                DATA: begin
                    if (bus.HREADY) begin
                        bus.M_DONE <= cur ? 2'b10 : 2'b01;
                        last       <= cur;
                        bus.HWRITE <= 1'b0;
                        state      <= IDLE;
                        if (!bus.HWRITE) bus.M_RDATA <= bus.HRDATA;
                    end
`ifdef AHB_ARB_TIMEOUT_EN
                    else if (cnt_nx == LIMIT) begin
                        bus.M_DONE  <= cur ? 2'b10 : 2'b01;
                        bus.TIMEOUT <= 1'b1;
                        last        <= cur;
                        bus.HWRITE  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt_nx[7:0];
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed table-driven bench for ahb_arbiter plus timeout corner sequences.
// Run with or without AHB_ARB_TIMEOUT_EN; DUT built with TIMEOUT_CYCLES=4.
module tb_ahb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_arbiter_if bus ();

    ahb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [31:0] rdata;
        logic [3:0]  haddr;
        logic        hwrite;
        logic [31:0] hwdata;
        logic        hvalid;
        logic        tmo;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [31:0] hrdata;
        logic        hready;
        out_t        exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t v[$];

    function automatic vec_t mk(
        input logic r, input logic [1:0] rq, input logic [1:0] w,
        input logic [7:0] a, input logic [63:0] wd,
        input logic [31:0] hr, input logic hy,
        input logic [1:0] g, input logic [1:0] d, input logic [31:0] rd,
        input logic [3:0] ha, input logic hw, input logic [31:0] hwd,
        input logic hv);
        vec_t t;
        t.rst = r; t.req = rq; t.wr = w; t.addr = a; t.wdata = wd;
        t.hrdata = hr; t.hready = hy;
        t.exp = '{gnt: g, done: d, rdata: rd, haddr: ha, hwrite: hw,
                  hwdata: hwd, hvalid: hv, tmo: 1'b0};
        return t;
    endfunction

    task automatic drive(input logic r, input logic [1:0] rq,
                         input logic [1:0] w, input logic [7:0] a,
                         input logic [63:0] wd, input logic [31:0] hr,
                         input logic hy);
        rst = r;
        bus.M_REQ = rq;
        bus.M_WRITE = w;
        bus.M_ADDR = a;
        bus.M_WDATA = wd;
        bus.HRDATA = hr;
        bus.HREADY = hy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input out_t e);
        out_t a;
        a = {bus.M_GNT, bus.M_DONE, bus.M_RDATA, bus.HADDR, bus.HWRITE,
             bus.HWDATA, bus.HVALID, bus.TIMEOUT};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b done=%b rdata=%h haddr=%h hwrite=%b hwdata=%h hvalid=%b tmo=%b, want gnt=%b done=%b rdata=%h haddr=%h hwrite=%b hwdata=%h hvalid=%b tmo=%b",
                     nm, a.gnt, a.done, a.rdata, a.haddr, a.hwrite,
                     a.hwdata, a.hvalid, a.tmo, e.gnt, e.done, e.rdata,
                     e.haddr, e.hwrite, e.hwdata, e.hvalid, e.tmo);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, a, e);
        end
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 8'h00, 64'h0, 32'h0, 1'b0);

        // reset
        v.push_back(mk(1,2'b00,2'b00,8'h00,64'h0,32'h0,0,
                       2'b00,2'b00,32'h0,4'h0,0,32'h0,0));
        // master 0 write, addr 3
        v.push_back(mk(0,2'b01,2'b01,8'h03,64'h0000_0000_DEAD_BEEF,32'h0,1,
                       2'b01,2'b00,32'h0,4'h3,1,32'hDEADBEEF,1));
        v.push_back(mk(0,2'b00,2'b00,8'hFF,64'hFFFF_FFFF_FFFF_FFFF,32'h0,1,
                       2'b00,2'b00,32'h0,4'h3,1,32'hDEADBEEF,0));
        v.push_back(mk(0,2'b00,2'b00,8'hFF,64'hFFFF_FFFF_FFFF_FFFF,32'hCAFEF00D,1,
                       2'b00,2'b01,32'h0,4'h3,0,32'hDEADBEEF,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h0,1,
                       2'b00,2'b00,32'h0,4'h3,0,32'hDEADBEEF,0));
        // master 1 read, addr A, two wait cycles
        v.push_back(mk(0,2'b10,2'b00,8'hA0,64'h1111_1111_0000_0000,32'h0,0,
                       2'b10,2'b00,32'h0,4'hA,0,32'h11111111,1));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h99999999,1,
                       2'b00,2'b00,32'h0,4'hA,0,32'h11111111,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h12345678,0,
                       2'b00,2'b00,32'h0,4'hA,0,32'h11111111,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h12345678,0,
                       2'b00,2'b00,32'h0,4'hA,0,32'h11111111,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h12345678,1,
                       2'b00,2'b10,32'h12345678,4'hA,0,32'h11111111,0));
        // reset, then both request continuously
        v.push_back(mk(1,2'b00,2'b00,8'h00,64'h0,32'h0,0,
                       2'b00,2'b00,32'h0,4'h0,0,32'h0,0));
        for (int k = 0; k < 3; k++) begin
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b01,2'b00,(k==0)?32'h0:32'h55555555,4'h1,1,32'hAAAA0000,1));
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b00,2'b00,(k==0)?32'h0:32'h55555555,4'h1,1,32'hAAAA0000,0));
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b01 & 2'b00,2'b01,(k==0)?32'h0:32'h55555555,4'h1,0,32'hAAAA0000,0));
            if (k == 2) break;
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b10,2'b00,(k==0)?32'h0:32'h55555555,4'h2,0,32'hBBBB0001,1));
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b00,2'b00,(k==0)?32'h0:32'h55555555,4'h2,0,32'hBBBB0001,0));
            v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                           2'b00,2'b10,32'h55555555,4'h2,0,32'hBBBB0001,0));
        end
        // fourth grant goes to master 1, then requests stop
        v.push_back(mk(0,2'b11,2'b01,8'h21,64'hBBBB_0001_AAAA_0000,32'h55555555,1,
                       2'b10,2'b00,32'h55555555,4'h2,0,32'hBBBB0001,1));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h66666666,1,
                       2'b00,2'b00,32'h55555555,4'h2,0,32'hBBBB0001,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h66666666,1,
                       2'b00,2'b10,32'h66666666,4'h2,0,32'hBBBB0001,0));
        // reset during DATA of master 0 aborts silently
        v.push_back(mk(0,2'b01,2'b01,8'h05,64'h0000_0000_0000_0005,32'h0,0,
                       2'b01,2'b00,32'h66666666,4'h5,1,32'h5,1));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h0,0,
                       2'b00,2'b00,32'h66666666,4'h5,1,32'h5,0));
        v.push_back(mk(1,2'b00,2'b00,8'h00,64'h0,32'h0,1,
                       2'b00,2'b00,32'h0,4'h0,0,32'h0,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h0,1,
                       2'b00,2'b00,32'h0,4'h0,0,32'h0,0));
        v.push_back(mk(0,2'b01,2'b00,8'h07,64'h0,32'h77777777,1,
                       2'b01,2'b00,32'h0,4'h7,0,32'h0,1));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h77777777,1,
                       2'b00,2'b00,32'h0,4'h7,0,32'h0,0));
        v.push_back(mk(0,2'b00,2'b00,8'h00,64'h0,32'h77777777,1,
                       2'b00,2'b01,32'h77777777,4'h7,0,32'h0,0));

        foreach (v[i]) begin
            drive(v[i].rst, v[i].req, v[i].wr, v[i].addr, v[i].wdata,
                  v[i].hrdata, v[i].hready);
            step();
            check($sformatf("vec%0d", i), v[i].exp);
        end

        // master 1 read with HREADY held low
        drive(0, 2'b10, 2'b00, 8'hC0, 64'h0, 32'hFFFFFFFF, 0);
        step();
        chk("to_gnt", 32'(bus.M_GNT), 32'h2);
        drive(0, 2'b00, 2'b00, 8'h00, 64'h0, 32'hFFFFFFFF, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("to_wait%0d", i),
                32'({bus.M_DONE, bus.TIMEOUT}), 32'h0);
        end
        step();
`ifdef AHB_ARB_TIMEOUT_EN
        chk("to_fire", 32'({bus.M_DONE, bus.TIMEOUT}), 32'h5);
        chk("to_rdata", bus.M_RDATA, 32'h77777777);
        step();
        chk("to_pulse", 32'({bus.M_DONE, bus.TIMEOUT}), 32'h0);
`else
        chk("to_hold0", 32'({bus.M_DONE, bus.TIMEOUT}), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("to_hold%0d", i + 1),
                32'({bus.M_DONE, bus.TIMEOUT}), 32'h0);
        end
        bus.HREADY = 1'b1;
        step();
        chk("to_late", 32'({bus.M_DONE, bus.TIMEOUT}), 32'h4);
        chk("to_late_rd", bus.M_RDATA, 32'hFFFFFFFF);
        bus.HREADY = 1'b0;
        step();
`endif

        // HREADY arrives on the edge the count would expire
        drive(0, 2'b01, 2'b00, 8'h0D, 64'h0, 32'h0000ABCD, 0);
        step();
        chk("edge_gnt", 32'(bus.M_GNT), 32'h1);
        drive(0, 2'b00, 2'b00, 8'h00, 64'h0, 32'h0000ABCD, 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("edge_wait%0d", i),
                32'({bus.M_DONE, bus.TIMEOUT}), 32'h0);
        end
        bus.HREADY = 1'b1;
        step();
        chk("edge_done", 32'({bus.M_DONE, bus.TIMEOUT}), 32'h2);
        chk("edge_rdata", bus.M_RDATA, 32'h0000ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max DATA-phase wait cycles before abort (only with AHB_ARB_TIMEOUT_EN); legal range 1..255.
REQ-002 HCLK  input  1  bus clock; all state changes on rising edge.
REQ-003 HRESET  input  1  reset, synchronous, active-high.
REQ-004 M_REQ  input  2  per-master request; bit n = master n.
REQ-005 M_WRITE  input  2  per-master direction, 1 = write.
REQ-006 M_ADDR  input  8  per-master address; master n at [4n+3:4n].
REQ-007 M_WDATA  input  64  per-master write data; master n at [32n+31:32n].
REQ-008 M_GNT  output  2  one-cycle grant pulse, one-hot.
REQ-009 M_DONE  output  2  one-cycle completion pulse, one-hot.
REQ-010 M_RDATA  output  32  read data of last completed read, shared by both masters.
REQ-011 HADDR  output  4  shared bus address.
REQ-012 HWRITE  output  1  shared bus direction.
REQ-013 HWDATA  output  32  shared bus write data.
REQ-014 HVALID  output  1  address phase valid.
REQ-015 HRDATA  input  32  slave read data.
REQ-016 HREADY  input  1  slave transfer complete.
REQ-017 TIMEOUT  output  1  one-cycle pulse, DATA phase aborted.

Function
REQ-018 FSM states IDLE, ADDR, DATA; all outputs registered or decoded from state only.
REQ-019 IDLE: requests present at an edge -> select winner; latch its ADDR/WRITE/WDATA; M_GNT[winner]=1 next cycle; go ADDR.
REQ-020 Arbitration round-robin: single requester wins; both requesting -> master != LAST wins; LAST = last completed master.
REQ-021 ADDR (exactly 1 cycle): HVALID=1, HADDR/HWRITE/HWDATA = latched values; next state DATA.
REQ-022 DATA: HVALID=0; HADDR/HWRITE/HWDATA held; HREADY=1 at edge -> M_DONE[winner]=1 next cycle, LAST<=winner, go IDLE.
REQ-023 Read completion: M_RDATA<=HRDATA on same edge as DONE; write completion leaves M_RDATA unchanged.
REQ-024 HREADY ignored outside DATA; HRDATA ignored except on a read-completion edge.
REQ-025 Latency: REQ sampled edge k -> GNT cycle k+1 -> HVALID cycle k+1 -> earliest DONE cycle k+3; one IDLE cycle between transfers.
REQ-026 Masters hold request fields stable until GNT; fields changing after GNT do not affect the transfer in flight.
REQ-027 Request dropped before GNT -> no transfer, no GNT.
REQ-028 IDLE: HWRITE=0, HVALID=0; HADDR/HWDATA keep last driven values.

Reset
REQ-029 HRESET=1 at edge -> state IDLE; M_GNT, M_DONE, M_RDATA, HADDR, HWRITE, HWDATA, HVALID, TIMEOUT all 0; LAST=1 (master 0 wins first tie).
REQ-030 Reset mid-transfer aborts it silently: no DONE, no TIMEOUT; requests seen only on edges with HRESET=0.

Configuration
REQ-031 Macro AHB_ARB_TIMEOUT_EN defined: 8-bit counter clears on ADDR->DATA, increments each DATA cycle with HREADY=0; reaching TIMEOUT_CYCLES without HREADY -> M_DONE[winner]=1 and TIMEOUT=1 together, M_RDATA unchanged, LAST<=winner, go IDLE.
REQ-032 HREADY=1 on the edge the count reaches TIMEOUT_CYCLES -> normal completion, no TIMEOUT.
REQ-033 Macro undefined: no counter; DATA waits indefinitely; TIMEOUT tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-034 Master 0 write ADDR=4'h3 WDATA=32'hDEADBEEF, HREADY=1 -> GNT[0] cycle 1, HVALID/HADDR=3/HWRITE=1 cycle 1, DONE[0] cycle 3.
REQ-035 Master 1 read ADDR=4'hA, HREADY low 2 DATA cycles, HRDATA=32'h12345678 -> DONE[1] cycle 5, M_RDATA=32'h12345678.
REQ-036 Both request continuously after reset -> grant order 0,1,0,1; one IDLE cycle between each DONE and next GNT.
REQ-037 HRESET asserted during DATA of master 0 -> next cycle all outputs 0, no DONE; new request after release granted normally.
REQ-038 With AHB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, HREADY held 0 -> DONE and TIMEOUT together 4 DATA cycles after entry, M_RDATA unchanged; without macro, bus stays in DATA, TIMEOUT never asserts.
